fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the combinational instruction ROM (11-bit address, 29-bit word, asynchronous read) and downstream of nothing but the core's control path. It owns the program counter, drives the ROM address and captures each returned word into a 2-entry prefetch buffer. The buffer presents instructions, tagged with their PC, to the decode stage over a valid/ready handshake. Branch/jump redirects flush the buffer, and a halt request parks the stage until the next redirect.

## Interface
Parameters:
- ADDR_W, 11, instruction address width (2048-word ROM)
- INSTR_W, 29, instruction word width
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- rom_addr  out  ADDR_W  address to ROM, equal to the pc register (combinational from the register only)
- rom_data  in  INSTR_W  ROM word for rom_addr, valid in the same cycle
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decode accepts the head this cycle
- instr_data  out  INSTR_W  head instruction word
- instr_pc  out  ADDR_W  address the head word was fetched from
- redirect  in  1  one-cycle pulse: discard everything and resume fetching at redirect_pc
- redirect_pc  in  ADDR_W  target of redirect
- halt_req  in  1  stop issuing new fetches; sticky until next redirect
- halted  out  1  state is HALT and buffer empty

## Operation
- States: RUN and HALT. Reset enters RUN with pc = RESET_PC, buffer empty.
- Fetch condition (RUN only): buffer count < 2, or count == 2 with a pop this cycle. When the fetch condition holds, the edge pushes {pc, rom_data} and sets pc <= pc + 1.
- PC arithmetic is modulo 2^ADDR_W: 2047 + 1 wraps to 0, with no flag.
- Pop: instr_valid && instr_ready. The buffer is FIFO ordered. instr_data and instr_pc hold stable while valid && !ready.
- Redirect has highest priority:
  - A pop in the same cycle completes; the accepted word counts.
  - All other entries are then discarded, and no push occurs that cycle.
  - pc <= redirect_pc, and state <= RUN (this also clears HALT).
- halt_req in RUN: no push that cycle, state <= HALT. In HALT, pc is frozen and the buffer drains through normal pops. halted = (state == HALT) && (count == 0).
- halt_req and redirect in the same cycle: redirect wins and the stage stays in RUN.

## Timing
- Reset values: rom_addr = RESET_PC, instr_valid = 0, instr_data = 0, instr_pc = 0, halted = 0, count = 0.
- Fetch latency: a word presented at rom_addr in cycle N appears at instr_valid/instr_data in cycle N+1 (empty buffer).
- Sustained throughput is 1 instruction per cycle with instr_ready held high.
- Redirect asserted in cycle N: instr_valid = 0 in N+1, the target word is valid in N+2. This is a one-bubble penalty.
- Back-pressure: with ready low, exactly 2 words buffer up, then fetch stalls and pc holds. When ready rises, pops and fetches resume the same cycle with no bubble.
- Reset assertion mid-operation clears everything immediately (asynchronous). The first fetch is from RESET_PC on the first edge after release.

## Structure
- Shared package cpu_pkg holds ADDR_W, INSTR_W, RESET_PC and the fetch-state encoding (RUN=0, HALT=1), for reuse by decode and the branch unit.
- One sub-module, fetch_buf: a 2-entry FIFO of {ADDR_W+INSTR_W} bits with push, pop, flush, count, and a head output. fetch_unit holds the pc, the state FSM and the fetch-condition logic.

## Test plan
- Reset release with ready=1 and ROM words at 0..4 → instr_pc sequence 0,1,2,3,4 on consecutive cycles, first valid one cycle after release, data matching ROM.
- ready=0 for 5 cycles from PC 0 → pc stops at 2, count = 2, head stays at pc 0. Raising ready yields 0,1,2,3 with no gap.
- Redirect to 0x012 while the head is pc 5 and ready=1 → pc 5 accepted, next cycle invalid, then 0x012, 0x013.
- Start at 2046 via redirect → instr_pc sequence 2046, 2047, 0, 1.
- halt_req pulse with 2 buffered and ready=1 → both drain, halted rises, pc frozen. A later redirect to 0x009 clears halted and fetches 0x009.
- Assert rst_n low mid-stream with valid=1 → instr_valid = 0 immediately, without waiting for a clock edge. After release, the fetch restarts at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared core widths, reset PC and fetch-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 29;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] c_st_run  = 1'b0;
    localparam logic [STATE_W-1:0] c_st_halt = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry FIFO holding {pc, instruction} pairs for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::ADDR_W + cpu_pkg::INSTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = pop && (r_count != 2'd0);
    // A full buffer accepts a push only when the head leaves in the same cycle.
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign count      = r_count;
    assign head_valid = (r_count != 2'd0);
    assign head_data  = head_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and ROM fetch stage feeding decode through a
//               two-entry prefetch buffer, with redirect flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               halted
);

    localparam int c_ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]    r_pc;
    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic                 w_pop;
    logic                 w_fetch;
    logic [1:0]           w_count;
    logic                 w_head_valid;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_pop = w_head_valid && instr_ready;

    // Redirect and halt both suppress this cycle's push.
    assign w_fetch = (r_state == c_st_run) && !redirect && !halt_req &&
                     ((w_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = c_st_run;
        end else if ((r_state == c_st_run) && halt_req) begin
            w_state_nxt = c_st_halt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_fetch) begin
            r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    fetch_buf #(
        .WIDTH (c_ENTRY_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_fetch),
        .push_data  ({r_pc, rom_data}),
        .pop        (w_pop),
        .flush      (redirect),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head_data  (w_head)
    );

    assign rom_addr    = r_pc;
    assign instr_valid = w_head_valid;
    assign instr_pc    = w_head[c_ENTRY_W-1:INSTR_W];
    assign instr_data  = w_head[INSTR_W-1:0];
    assign halted      = (r_state == c_st_halt) && (w_count == 2'd0);

endmodule
`default_nettype wire
